// File: rtl/audio_pwm_dac_mc_if.sv
// Peripheral register bus for audio_pwm_dac_mc: 4-bit address, 16-bit data,
// select plus read/write strobes. Read data is combinational from Addr.
interface audio_pwm_dac_mc_if;
    logic [3:0]  Addr;
    logic [15:0] DataWr;
    logic [15:0] DataRd;
    logic        En;
    logic        Rd;
    logic        Wr;

    modport master (output Addr, output DataWr, output En, output Rd, output Wr, input DataRd);
    modport slave  (input Addr, input DataWr, input En, input Rd, input Wr, output DataRd);
endinterface

// File: rtl/audio_pwm_dac_mc.sv
// Serial stereo audio receiver with stereo-pair FIFO, mix/scale/saturate and PWM rendering,
// plus a tone generator, silence timeout and status/flush registers.
module audio_pwm_dac_mc #(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned PWM_W      = 10,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT_W  = 12
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Async,
    input  logic                AbitClk,
    input  logic                Asdo,
    output logic                Asdi,
    output logic                Out,
    audio_pwm_dac_mc_if.slave   bus
);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned BCW = $clog2(SAMPLE_W + 1);
    localparam int unsigned PW  = 2 * SAMPLE_W;
    localparam int unsigned MW  = SAMPLE_W + 1;
    localparam int unsigned XW  = MW + 9;

    localparam logic [1:0] ModeOff    = 2'b00;
    localparam logic [1:0] ModeTone   = 2'b01;
    localparam logic [1:0] ModeStream = 2'b10;

    localparam logic [BCW-1:0] BitsFull = BCW'(SAMPLE_W);
    localparam logic [CW-1:0]  CntFull  = CW'(FIFO_DEPTH);
    localparam logic signed [XW-1:0] SatMax =
        {{(XW - SAMPLE_W + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
    localparam logic signed [XW-1:0] SatMin = ~SatMax;

    // Synchronisers and edge detect
    logic [1:0] async_sync_q, async_sync_d, bclk_sync_q, bclk_sync_d, asdo_sync_q, asdo_sync_d;
    logic       async_prev_q, async_prev_d, bclk_prev_q, bclk_prev_d;
    // Capture
    logic [BCW-1:0]      bitcnt_q, bitcnt_d;
    logic [SAMPLE_W-1:0] left_sr_q, left_sr_d, right_sr_q, right_sr_d, left_lat_q, left_lat_d;
    logic                left_valid_q, left_valid_d;
    // FIFO
    logic [PW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    // Registers
    logic [1:0]  mode_q, mode_d, mix_q, mix_d;
    logic [7:0]  volume_q, volume_d;
    logic [15:0] freq_q, freq_d;
    logic        ovf_q, ovf_d, unf_q, unf_d;
    // PWM / timeout
    logic [PWM_W-1:0]     pwm_cnt_q, pwm_cnt_d, duty_q, duty_d, duty_new;
    logic [PW-1:0]        pair_q, pair_d, cur_pair;
    logic [SAMPLE_W-1:0]  prev_sat_q, prev_sat_d, sat;
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    // Tone
    logic [20:0] tone_div_q, tone_div_d;
    logic        tone_q, tone_d, vol_q, vol_d, out_q, out_d;
    logic [7:0]  vol_cnt_q, vol_cnt_d;

    logic async_s, async_rise, async_fall, bclk_rise, bits_full;
    logic push_req, push_ok, pop_do, empty, full, ovf_set, unf_set;
    logic we, flush, enter_stream, stream, period_start, tmo;
    logic signed [MW-1:0] l_x, r_x, sum_x, mix_x;
    logic signed [XW-1:0] mix_w, vol_w, prod, scaled;
    logic unused_rd;

    assign unused_rd = bus.Rd;
    assign Asdi      = 1'b0;
    assign Out       = out_q;

    assign async_s    = async_sync_q[1];
    assign async_rise = async_s & ~async_prev_q;
    assign async_fall = ~async_s & async_prev_q;
    assign bclk_rise  = bclk_sync_q[1] & ~bclk_prev_q;
    assign bits_full  = (bitcnt_q == BitsFull);

    assign async_sync_d = {async_sync_q[0], Async};
    assign bclk_sync_d  = {bclk_sync_q[0], AbitClk};
    assign asdo_sync_d  = {asdo_sync_q[0], Asdo};
    assign async_prev_d = async_s;
    assign bclk_prev_d  = bclk_sync_q[1];

    always_comb begin
        bitcnt_d     = bitcnt_q;
        left_sr_d    = left_sr_q;
        right_sr_d   = right_sr_q;
        left_lat_d   = left_lat_q;
        left_valid_d = left_valid_q;
        push_req     = 1'b0;
        if (async_rise || async_fall) begin
            bitcnt_d = '0;
        end else if (bclk_rise && !bits_full) begin
            bitcnt_d = bitcnt_q + 1'b1;
            if (async_s) right_sr_d = {right_sr_q[SAMPLE_W-2:0], asdo_sync_q[1]};
            else         left_sr_d  = {left_sr_q[SAMPLE_W-2:0], asdo_sync_q[1]};
        end
        if (async_rise) begin
            left_valid_d = bits_full;
            if (bits_full) left_lat_d = left_sr_q;
        end
        if (async_fall) begin
            push_req     = bits_full & left_valid_q;
            left_valid_d = 1'b0;
        end
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntFull);
    assign stream  = (mode_q == ModeStream);
    assign period_start = stream & (pwm_cnt_q == '0);
    assign pop_do  = period_start & ~empty & ~flush;
    // A simultaneous pop frees the slot, so a push to a full FIFO still lands.
    assign push_ok = push_req & (~full | pop_do);
    assign ovf_set = push_req & ~push_ok;
    assign unf_set = period_start & empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = {left_lat_q, right_sr_q};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_do) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_do})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    assign we           = bus.En & bus.Wr;
    assign flush        = we & (bus.Addr == 4'd0) & bus.DataWr[4];
    assign enter_stream = we & (bus.Addr == 4'd0) & (bus.DataWr[1:0] == ModeStream) & ~stream;

    always_comb begin
        mode_d   = mode_q;
        mix_d    = mix_q;
        volume_d = volume_q;
        freq_d   = freq_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (we) begin
            unique case (bus.Addr)
                4'd0: begin
                    mode_d = bus.DataWr[1:0];
                    mix_d  = bus.DataWr[3:2];
                end
                4'd1: volume_d = bus.DataWr[7:0];
                4'd2: freq_d   = bus.DataWr;
                4'd3: begin
                    if (bus.DataWr[0]) ovf_d = 1'b0;
                    if (bus.DataWr[1]) unf_d = 1'b0;
                end
                default: ;
            endcase
        end
        if (ovf_set) ovf_d = 1'b1;
        if (unf_set) unf_d = 1'b1;
    end

    always_comb begin
        bus.DataRd = '0;
        unique case (bus.Addr)
            4'd0:    bus.DataRd = {12'h000, mix_q, mode_q};
            4'd1:    bus.DataRd = {8'h00, volume_q};
            4'd2:    bus.DataRd = freq_q;
            4'd3:    bus.DataRd = {8'(count_q), 5'b00000, tmo, unf_q, ovf_q};
            default: bus.DataRd = '0;
        endcase
    end

    // Mix, scale and saturate the pair that is current for this period.
    always_comb begin
        cur_pair = pop_do ? mem_q[rd_ptr_q] : pair_q;
        l_x      = {cur_pair[PW-1], cur_pair[PW-1:SAMPLE_W]};
        r_x      = {cur_pair[SAMPLE_W-1], cur_pair[SAMPLE_W-1:0]};
        sum_x    = l_x + r_x;
        unique case (mix_q)
            2'b01:   mix_x = l_x;
            2'b10:   mix_x = r_x;
            default: mix_x = sum_x >>> 1;
        endcase
        mix_w  = {{(XW - MW){mix_x[MW-1]}}, mix_x};
        vol_w  = {{(XW - 8){1'b0}}, volume_q};
        prod   = mix_w * vol_w;
        scaled = prod >>> 7;
        if (scaled > SatMax)      sat = SatMax[SAMPLE_W-1:0];
        else if (scaled < SatMin) sat = SatMin[SAMPLE_W-1:0];
        else                      sat = scaled[SAMPLE_W-1:0];
        if (volume_q == 8'd0) duty_new = '0;
        else                  duty_new = {~sat[SAMPLE_W-1], sat[SAMPLE_W-2 -: PWM_W-1]};
    end

    assign tmo = &tmo_cnt_q;

    always_comb begin
        pwm_cnt_d  = enter_stream ? '0 : pwm_cnt_q + 1'b1;
        pair_d     = cur_pair;
        duty_d     = duty_q;
        prev_sat_d = prev_sat_q;
        tmo_cnt_d  = tmo_cnt_q;
        if (period_start) begin
            duty_d     = duty_new;
            prev_sat_d = sat;
            if (sat != prev_sat_q) tmo_cnt_d = '0;
            else if (!tmo)         tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_comb begin
        tone_div_d = tone_div_q;
        tone_d     = tone_q;
        if (mode_q != ModeTone) begin
            tone_div_d = '0;
            tone_d     = 1'b0;
        end else if (tone_div_q >= {freq_q, 5'h1f}) begin
            tone_div_d = '0;
            tone_d     = ~tone_q;
        end else begin
            tone_div_d = tone_div_q + 1'b1;
        end
        vol_cnt_d = vol_cnt_q + 1'b1;
        vol_d     = (vol_cnt_q < volume_q);
        unique case (mode_q)
            ModeStream: out_d = ~tmo & (pwm_cnt_q < duty_d);
            ModeTone:   out_d = tone_q & vol_q;
            default:    out_d = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            async_sync_q <= '0;
            bclk_sync_q  <= '0;
            asdo_sync_q  <= '0;
            async_prev_q <= 1'b0;
            bclk_prev_q  <= 1'b0;
            bitcnt_q     <= '0;
            left_sr_q    <= '0;
            right_sr_q   <= '0;
            left_lat_q   <= '0;
            left_valid_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mode_q       <= ModeOff;
            mix_q        <= 2'b00;
            volume_q     <= 8'h80;
            freq_q       <= 16'h0000;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            pwm_cnt_q    <= '0;
            pair_q       <= '0;
            duty_q       <= '0;
            prev_sat_q   <= '0;
            tmo_cnt_q    <= '0;
            tone_div_q   <= '0;
            tone_q       <= 1'b0;
            vol_cnt_q    <= '0;
            vol_q        <= 1'b0;
            out_q        <= 1'b0;
        end else begin
            async_sync_q <= async_sync_d;
            bclk_sync_q  <= bclk_sync_d;
            asdo_sync_q  <= asdo_sync_d;
            async_prev_q <= async_prev_d;
            bclk_prev_q  <= bclk_prev_d;
            bitcnt_q     <= bitcnt_d;
            left_sr_q    <= left_sr_d;
            right_sr_q   <= right_sr_d;
            left_lat_q   <= left_lat_d;
            left_valid_q <= left_valid_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mode_q       <= mode_d;
            mix_q        <= mix_d;
            volume_q     <= volume_d;
            freq_q       <= freq_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            pwm_cnt_q    <= pwm_cnt_d;
            pair_q       <= pair_d;
            duty_q       <= duty_d;
            prev_sat_q   <= prev_sat_d;
            tmo_cnt_q    <= tmo_cnt_d;
            tone_div_q   <= tone_div_d;
            tone_q       <= tone_d;
            vol_cnt_q    <= vol_cnt_d;
            vol_q        <= vol_d;
            out_q        <= out_d;
        end
    end
endmodule

// File: tb/tb_audio_pwm_dac_mc.sv
// Randomized self-checking bench for audio_pwm_dac_mc: serial frames in, PWM duty, FIFO level,
// flags and tone output compared against an arithmetic reference model.
module tb_audio_pwm_dac_mc;
    localparam int W     = 16;
    localparam int PWMW  = 10;
    localparam int DEPTH = 8;
    localparam int TW    = 4;
    localparam int PER   = 1 << PWMW;

    logic Clk = 1'b0;
    logic Reset, Async, AbitClk, Asdo, Asdi, Out;
    audio_pwm_dac_mc_if bus ();

    audio_pwm_dac_mc #(
        .SAMPLE_W  (W),
        .PWM_W     (PWMW),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_W (TW)
    ) u_dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Async  (Async),
        .AbitClk(AbitClk),
        .Asdo   (Asdo),
        .Asdi   (Asdi),
        .Out    (Out),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int mq_level;
    bit m_ovf;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge Clk);
        bus.Addr = a; bus.DataWr = d; bus.En = 1'b1; bus.Wr = 1'b1;
        @(negedge Clk);
        bus.En = 1'b0; bus.Wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [15:0] d);
        @(negedge Clk);
        bus.Addr = a; bus.En = 1'b1; bus.Rd = 1'b1;
        #1 d = bus.DataRd;
        @(negedge Clk);
        bus.En = 1'b0; bus.Rd = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        Asdo = b; AbitClk = 1'b0;
        wait_clks(4);
        AbitClk = 1'b1;
        wait_clks(4);
    endtask

    // Dummy rise/fall first so every frame starts from a clean bit count.
    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
        Async = 1'b1; wait_clks(4);
        Async = 1'b0; wait_clks(4);
        for (int i = W - 1; i >= 0; i--) send_bit(l[i]);
        Async = 1'b1; wait_clks(4);
        for (int i = W - 1; i >= 0; i--) send_bit(r[i]);
        Async = 1'b0; wait_clks(8);
    endtask

    function automatic int ref_duty(input logic [W-1:0] l, input logic [W-1:0] r,
                                    input int mix, input int vol);
        int sl, sr, m, s;
        sl = int'($signed(l));
        sr = int'($signed(r));
        if (mix == 1)      m = sl;
        else if (mix == 2) m = sr;
        else               m = (sl + sr) >>> 1;
        s = (m * vol) >>> 7;
        if (s > (1 << (W - 1)) - 1) s = (1 << (W - 1)) - 1;
        if (s < -(1 << (W - 1)))    s = -(1 << (W - 1));
        if (vol == 0) return 0;
        return (s + (1 << (W - 1))) >> (W - PWMW);
    endfunction

    task automatic measure(input int n, output int hi, output int max_hi);
        int run;
        hi = 0; max_hi = 0; run = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (Out) begin
                hi++; run++;
                if (run > max_hi) max_hi = run;
            end else begin
                run = 0;
            end
        end
    endtask

    task automatic run_case(input string tag, input logic [W-1:0] l, input logic [W-1:0] r,
                            input int mix, input int vol, input bit chk_unf);
        logic [15:0] d;
        int hi, mh;
        bus_wr(4'd0, 16'h0010);
        bus_wr(4'd3, 16'h0003);
        send_frame(l, r);
        bus_rd(4'd3, d);
        check_eq($sformatf("%s_lvl1", tag), int'(d[15:8]), 1);
        bus_wr(4'd1, 16'(vol));
        bus_wr(4'd0, 16'({mix[1:0], 2'b10}));
        wait_clks(4);
        bus_rd(4'd3, d);
        check_eq($sformatf("%s_lvl0", tag), int'(d[15:8]), 0);
        wait_clks(PER + 80);
        measure(PER, hi, mh);
        check_eq($sformatf("%s_duty", tag), hi, ref_duty(l, r, mix, vol));
        if (chk_unf) begin
            bus_rd(4'd3, d);
            check_eq($sformatf("%s_unf", tag), int'(d[1]), 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within bound");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        logic [W-1:0] l, r;
        int hi, mh;
        Reset = 1'b1; Async = 1'b0; AbitClk = 1'b0; Asdo = 1'b0;
        bus.Addr = '0; bus.DataWr = '0; bus.En = 1'b0; bus.Rd = 1'b0; bus.Wr = 1'b0;
        wait_clks(3);
        #1 check_eq("rst_out", int'(Out), 0);
        Reset = 1'b0;
        wait_clks(2);
        bus_rd(4'd0, d); check_eq("rst_ctrl", int'(d), 16'h0000);
        bus_rd(4'd1, d); check_eq("rst_vol", int'(d), 16'h0080);
        bus_rd(4'd2, d); check_eq("rst_freq", int'(d), 16'h0000);
        bus_rd(4'd3, d); check_eq("rst_status", int'(d), 16'h0000);
        bus_wr(4'd9, 16'hffff);
        bus_rd(4'd9, d); check_eq("unmapped_rd", int'(d), 0);
        bus_rd(4'd1, d); check_eq("unmapped_wr", int'(d), 16'h0080);
        check_eq("asdi", int'(Asdi), 0);

        // Directed stream cases
        run_case("unity", 16'h4000, 16'h4000, 0, 8'h80, 1'b1);
        run_case("satpos", 16'h7fff, 16'h7fff, 0, 8'hff, 1'b0);
        run_case("satneg", 16'h8000, 16'h8000, 0, 8'hff, 1'b0);
        run_case("vol0", 16'h1234, 16'h5678, 1, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            l = W'($urandom);
            r = W'($urandom);
            run_case($sformatf("rnd%0d", i), l, r, int'($urandom_range(0, 3)),
                     int'($urandom_range(1, 255)), 1'b0);
        end

        // Overflow with no consumer
        bus_wr(4'd0, 16'h0010);
        bus_wr(4'd3, 16'h0003);
        mq_level = 0; m_ovf = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            send_frame(W'($urandom), W'($urandom));
            if (mq_level < DEPTH) mq_level++;
            else m_ovf = 1'b1;
        end
        bus_rd(4'd3, d);
        check_eq("ovf_level", int'(d[15:8]), mq_level);
        check_eq("ovf_flag", int'(d[0]), int'(m_ovf));
        bus_wr(4'd3, 16'h0001);
        bus_rd(4'd3, d);
        check_eq("ovf_clr", int'(d[0]), 0);
        check_eq("ovf_clr_level", int'(d[15:8]), DEPTH);
        bus_wr(4'd0, 16'h0010);
        bus_rd(4'd3, d);
        check_eq("flush_level", int'(d[15:8]), 0);

        // Underflow and silence timeout
        bus_wr(4'd3, 16'h0003);
        send_frame(16'h2000, 16'h2000);
        bus_wr(4'd1, 16'h0080);
        bus_wr(4'd0, 16'h0002);
        wait_clks(2 * PER + 100);
        bus_rd(4'd3, d);
        check_eq("unf_set", int'(d[1]), 1);
        check_eq("tmo_early", int'(d[2]), 0);
        wait_clks(18 * PER);
        bus_rd(4'd3, d);
        check_eq("tmo_set", int'(d[2]), 1);
        measure(PER, hi, mh);
        check_eq("tmo_out", hi, 0);
        send_frame(16'h6000, 16'h6000);
        wait_clks(2 * PER);
        bus_rd(4'd3, d);
        check_eq("tmo_clr", int'(d[2]), 0);
        measure(PER, hi, mh);
        check_eq("tmo_resume", hi, ref_duty(16'h6000, 16'h6000, 0, 8'h80));

        // Tone: FREQ=1 toggles every 64, FREQ=0 every 32; one volume-gap cycle per 256
        bus_wr(4'd2, 16'h0001);
        bus_wr(4'd1, 16'h00ff);
        bus_wr(4'd0, 16'h0001);
        wait_clks(300);
        measure(1024, hi, mh);
        check_eq("tone1_hi", int'(hi == 508 || hi == 512), 1);
        check_eq("tone1_run", mh, 64);
        bus_wr(4'd2, 16'h0000);
        wait_clks(300);
        measure(1024, hi, mh);
        check_eq("tone0_hi", int'(hi == 508 || hi == 512), 1);
        check_eq("tone0_run", mh, 32);

        bus_wr(4'd0, 16'h0000);
        wait_clks(3);
        measure(200, hi, mh);
        check_eq("off_out", hi, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/audio_pwm_dac_mc.md
Name: audio_pwm_dac_mc

Overview:
Parametrised successor to the serial-audio PWM DAC. It receives left-justified stereo serial audio (Async frame clock, AbitClk bit clock, Asdo data) of configurable sample width and buffers sample pairs in a FIFO. It then mixes, scales and saturates each sample and renders it as a PWM of configurable resolution on a single speaker pin. It also provides a tone-generator mode, silence timeout, and status/flush registers on the 16-bit peripheral bus.

Parameters:
SAMPLE_W, 16, bits captured per channel (8..24), MSB first.
PWM_W, 10, PWM resolution; period = 2^PWM_W Clk cycles.
FIFO_DEPTH, 8, stereo-pair FIFO entries; power of 2, at least 2.
TIMEOUT_W, 12, silence-timeout counter width.

Ports:
Clk  in  1  system clock; all logic is on its rising edge.
Reset  in  1  asynchronous, active-high reset.
Async  in  1  serial frame clock; low = left channel, high = right channel.
AbitClk  in  1  serial bit clock.
Asdo  in  1  serial audio data input.
Asdi  out  1  capture data to the codec; tied to 0.
Out  out  1  PWM/tone speaker output.
Addr  in  4  register address.
DataWr  in  16  write data.
DataRd  out  16  read data; combinational from Addr.
En  in  1  peripheral select.
Rd  in  1  read strobe; reads have no side effects.
Wr  in  1  write strobe; a write occurs when En & Wr.

Behaviour:
- Reset values: Out=0, all registers at defaults, FIFO empty, all flags 0, PWM counter 0. Asdi is constant 0.
- Synchronisers: Async, AbitClk and Asdo each pass through 2 flops. Edges are detected on the synchronised signals only.
- Capture:
  - Every Async edge clears the bit counter.
  - On each AbitClk rising edge, if bitcount < SAMPLE_W, shift Asdo into the left or right shift register (selected by synchronised Async) and increment bitcount. Bits beyond SAMPLE_W are ignored.
  - On an Async rising edge, latch the left register (if SAMPLE_W bits were received).
  - On an Async falling edge, if the right channel is complete and a left value is latched, push {L,R} into the FIFO. Pushes happen in every mode.
- FIFO:
  - If full at push time, the pair is dropped and OVF is set (sticky).
  - Push and pop in the same cycle are both performed and the level is unchanged. If full, a simultaneous pop makes room, so the push is accepted.
  - FLUSH empties the FIFO and overrides a same-cycle push or pop.
- PWM (mode STREAM):
  - Free-running counter pwm_cnt of PWM_W bits.
  - When pwm_cnt == 0, pop one pair if the FIFO is non-empty. If it is empty, reuse the last pair and set UNF (sticky).
  - Mix (signed, SAMPLE_W+1 bits internally): MIX=00 gives (L+R)>>>1, 01 gives L, 10 gives R, 11 gives (L+R)>>>1.
  - Scale: product = mix * VOLUME (VOLUME unsigned 8-bit; 0x80 = unity), then arithmetic shift right by 7.
  - Saturate the scaled value to a signed SAMPLE_W range.
  - duty = top PWM_W bits of the saturated value with the MSB inverted (offset binary). duty is loaded at pwm_cnt == 0.
  - Out = (pwm_cnt < duty). duty 0 gives constant low; duty max gives high for 2^PWM_W-1 cycles.
  - VOLUME == 0 forces duty to 0.
- Silence timeout:
  - At each period start, compare the saturated sample with the previous one.
  - If different, clear the timeout counter. If equal, increment the counter, saturating at all-ones.
  - When the counter is at all-ones, TMO=1 and Out is forced to 0 in STREAM mode.
- Tone (mode TONE):
  - Divider toggles tone_q every (FREQ+1)*32 Clk cycles. FREQ = 0 gives a toggle every 32 cycles.
  - vol_q is high while an 8-bit free counter is < VOLUME.
  - Out = tone_q & vol_q.
- Mode OFF (00) or 11: Out=0 on the next Clk.
- Mode changes take effect on the next Clk. Entering STREAM also restarts pwm_cnt at 0.
- Registers:
  - 0 CTRL: [1:0] MODE (00 off, 01 tone, 10 stream); [3:2] MIX; [4] FLUSH (write-1 pulse, reads 0). Reset 0x0000.
  - 1 VOLUME: [7:0]. Reset 0x0080.
  - 2 FREQ: [15:0]. Reset 0x0000.
  - 3 STATUS: [0] OVF, [1] UNF, [2] TMO (read-only), [15:8] FIFO level. Writing 1 to bit 0 or 1 clears that flag. A same-cycle set wins over the clear.
  - Other addresses read 0x0000; writes to them are ignored.

Test Plan:
- Reset -> Out=0, CTRL=0x0000, VOLUME=0x0080, FREQ=0x0000, STATUS=0x0000.
- STREAM, MIX=00, VOLUME=0x80, one frame L=R=0x4000 -> duty 0x300. Out high for 768 of every 1024 Clk cycles. STATUS level returns to 0 after the pop.
- VOLUME=0xFF, L=R=0x7FFF -> saturates to 0x7FFF, duty 1023. L=R=0x8000 -> duty 0, Out constant low.
- MODE=OFF, send 9 frames -> level=8, OVF=1. Write STATUS=0x0001 -> OVF=0. Write CTRL FLUSH -> level=0.
- STREAM with FIFO empty after one frame -> UNF=1, the same duty repeats. Hold the constant sample for 4095 periods -> TMO=1, Out=0. A new differing frame -> TMO=0 and PWM resumes.
- TONE, FREQ=1, VOLUME=0xFF -> tone_q toggles every 64 Clk cycles. Out is low for the 1 of every 256 cycles where vol_q is low.
